// File: rtl/sram_port0_arbiter_if.sv
// Requester-side bus of the SRAM port-0 arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_we/req_wmask/req_addr/req_wdata : command fields, packed per requester
//   rsp_valid           : one-hot read-return strobe
//   rsp_data            : read word, shared by all requesters
// slave  : the arbiter side
// master : the requester side (bus adapters or a bench)
interface sram_port0_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_ADDRESSES = 1024,
  parameter int NUM_REQ       = 2
);
  localparam int AW = $clog2(NUM_ADDRESSES);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0]              req_we;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wmask;
  logic [NUM_REQ*AW-1:0]           req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata;
  logic [NUM_REQ-1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]           rsp_data;

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sram_port0_arbiter.sv
// Round-robin arbiter and sequencer for port 0 (read/write) of the SKY130
// SRAM array. One access per cycle is granted; the command is registered onto
// the active-low array controls, and reads are tracked through a latency
// pipeline tagged with the requester ID so each word returns to its issuer.
//   clk0, rst0   : single clock, synchronous active-high reset
//   bus          : requester handshake, commands and read returns
//   mem_csb0     : array chip select (active-low)
//   mem_web0     : array write enable (active-low)
//   mem_wmask0   : array byte mask
//   mem_address  : array word address
//   mem_datain   : array write data
//   mem_dataout  : array read data
// The bus interface instance must be built with the same DATA_WIDTH,
// NUM_ADDRESSES and NUM_REQ as this module.
module sram_port0_arbiter #(
  parameter  int DATA_WIDTH    = 32,
  parameter  int NUM_ADDRESSES = 1024,
  parameter  int NUM_REQ       = 2,
  parameter  int READ_LATENCY  = 2,
  localparam int AW            = $clog2(NUM_ADDRESSES),
  localparam int IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int MW            = DATA_WIDTH / 8
) (
  input  logic                    clk0,
  input  logic                    rst0,
  sram_port0_arbiter_if.slave     bus,
  output logic                    mem_csb0,
  output logic                    mem_web0,
  output logic [MW-1:0]           mem_wmask0,
  output logic [AW-1:0]           mem_address,
  output logic [DATA_WIDTH-1:0]   mem_datain,
  input  logic [DATA_WIDTH-1:0]   mem_dataout
);

  // One stage beyond the array latency: the command spends a cycle on the
  // mem_* registers before the array captures it.
  localparam int PD = READ_LATENCY + 1;

  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         grant_id;
  logic                  grant_found;
  logic                  accept;

  logic                  sel_we;
  logic [MW-1:0]         sel_wmask;
  logic [AW-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  mem_csb0_q, mem_web0_q;
  logic [MW-1:0]         mem_wmask0_q;
  logic [AW-1:0]         mem_address_q;
  logic [DATA_WIDTH-1:0] mem_datain_q;

  logic [PD-1:0]         pipe_vld_q;
  logic [IW-1:0]         pipe_id_q [PD];

  logic [NUM_REQ-1:0]    rsp_valid_d, rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  // Round-robin search from ptr upward with wrap: first pass covers
  // ptr..NUM_REQ-1, second pass covers 0..ptr-1.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && (i >= int'(ptr_q)) && bus.req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = IW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && (i < int'(ptr_q)) && bus.req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = IW'(i);
      end
    end
  end

  assign accept = grant_found & ~rst0;
  assign ptr_d  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    sel_we        = 1'b0;
    sel_wmask     = '0;
    sel_addr      = '0;
    sel_wdata     = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IW'(i)) begin
        sel_we           = bus.req_we[i];
        sel_wmask        = bus.req_wmask[i*MW +: MW];
        sel_addr         = bus.req_addr[i*AW +: AW];
        sel_wdata        = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        bus.req_ready[i] = accept;
      end
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = pipe_vld_q[PD-1] && (pipe_id_q[PD-1] == IW'(i));
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      ptr_q         <= '0;
      mem_csb0_q    <= 1'b1;
      mem_web0_q    <= 1'b1;
      mem_wmask0_q  <= '0;
      mem_address_q <= '0;
      mem_datain_q  <= '0;
      pipe_vld_q    <= '0;
      for (int s = 0; s < PD; s++) begin
        pipe_id_q[s] <= '0;
      end
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      if (accept) begin
        ptr_q         <= ptr_d;
        mem_csb0_q    <= 1'b0;
        mem_web0_q    <= ~sel_we;
        mem_wmask0_q  <= sel_we ? sel_wmask : '1;
        mem_address_q <= sel_addr;
        mem_datain_q  <= sel_wdata;
      end else begin
        // Idle: deselect, leave address/data/mask as they were.
        mem_csb0_q    <= 1'b1;
        mem_web0_q    <= 1'b1;
      end

      for (int s = PD - 1; s > 0; s--) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_id_q[s]  <= pipe_id_q[s-1];
      end
      pipe_vld_q[0] <= accept & ~sel_we;
      pipe_id_q[0]  <= grant_id;

      rsp_valid_q <= rsp_valid_d;
      if (pipe_vld_q[PD-1]) begin
        rsp_data_q <= mem_dataout;
      end
    end
  end

  assign mem_csb0      = mem_csb0_q;
  assign mem_web0      = mem_web0_q;
  assign mem_wmask0    = mem_wmask0_q;
  assign mem_address   = mem_address_q;
  assign mem_datain    = mem_datain_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Bench for sram_port0_arbiter: a cycle table of stimulus and hand-computed
// expectations, plus a hand-written reset-during-read sequence. The array is
// modelled with byte-masked writes and a two-stage read delay line.
module tb_sram_port0_arbiter;

  localparam int DW = 32;
  localparam int NA = 1024;
  localparam int NR = 2;
  localparam int RL = 2;
  localparam int AW = 10;

  logic          clk0;
  logic          rst0;
  logic          mem_csb0, mem_web0;
  logic [3:0]    mem_wmask0;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_datain, mem_dataout;

  sram_port0_arbiter_if #(.DATA_WIDTH(DW), .NUM_ADDRESSES(NA), .NUM_REQ(NR)) bus ();

  sram_port0_arbiter #(
    .DATA_WIDTH(DW), .NUM_ADDRESSES(NA), .NUM_REQ(NR), .READ_LATENCY(RL)
  ) dut (
    .clk0        (clk0),
    .rst0        (rst0),
    .bus         (bus),
    .mem_csb0    (mem_csb0),
    .mem_web0    (mem_web0),
    .mem_wmask0  (mem_wmask0),
    .mem_address (mem_address),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // Array model: contents preset to 0xA500_0000 | address.
  logic [DW-1:0] mem [NA];
  logic [DW-1:0] dly0, dly1;
  initial begin
    for (int i = 0; i < NA; i++) mem[i] = 32'hA500_0000 | i;
    dly0 = '0;
    dly1 = '0;
  end
  always @(posedge clk0) begin
    logic [DW-1:0] w;
    if (!mem_csb0 && !mem_web0) begin
      w = mem[mem_address];
      for (int b = 0; b < 4; b++) if (mem_wmask0[b]) w[b*8 +: 8] = mem_datain[b*8 +: 8];
      mem[mem_address] <= w;
    end
    dly1 <= dly0;
    dly0 <= (!mem_csb0 && mem_web0) ? mem[mem_address] : 32'h0;
  end
  assign mem_dataout = dly1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [1:0]  we;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic [3:0]  m0;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic [3:0]  m1;
    logic [1:0]  e_rdy;
    logic        e_csb;
    logic        e_web;
    logic [1:0]  e_rv;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t v(logic rst, logic [1:0] vld, logic [1:0] we,
                             logic [9:0] a0, logic [31:0] d0, logic [3:0] m0,
                             logic [9:0] a1, logic [31:0] d1, logic [3:0] m1,
                             logic [1:0] e_rdy, logic e_csb, logic e_web,
                             logic [1:0] e_rv, logic [31:0] e_rd);
    vec_t r;
    r.rst = rst; r.vld = vld; r.we = we;
    r.a0 = a0; r.d0 = d0; r.m0 = m0;
    r.a1 = a1; r.d1 = d1; r.m1 = m1;
    r.e_rdy = e_rdy; r.e_csb = e_csb; r.e_web = e_web;
    r.e_rv = e_rv; r.e_rd = e_rd;
    return r;
  endfunction

  task automatic drive(input logic rst, input logic [1:0] vld, input logic [1:0] we,
                       input logic [9:0] a0, input logic [31:0] d0, input logic [3:0] m0,
                       input logic [9:0] a1, input logic [31:0] d1, input logic [3:0] m1);
    rst0          = rst;
    bus.req_valid = vld;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    bus.req_wmask = {m1, m0};
  endtask

  vec_t tbl [37];

  initial begin
    // Inputs for a row are applied before edge N; checks see the ready for
    // those inputs and the registered state left by edge N-1.
    tbl[0]  = v(1, 2'b11, 2'b00, 10'h010, 0, 0, 10'h020, 0, 0, 2'b00, 1, 1, 2'b00, 0);
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = v(0, 2'b11, 2'b00, 10'h010, 0, 0, 10'h020, 0, 0, 2'b01, 1, 1, 2'b00, 0);
    tbl[4]  = v(0, 2'b11, 2'b00, 10'h010, 0, 0, 10'h020, 0, 0, 2'b10, 0, 1, 2'b00, 0);
    tbl[5]  = v(0, 2'b11, 2'b00, 10'h010, 0, 0, 10'h020, 0, 0, 2'b01, 0, 1, 2'b00, 0);
    tbl[6]  = v(0, 2'b11, 2'b00, 10'h010, 0, 0, 10'h020, 0, 0, 2'b10, 0, 1, 2'b00, 0);
    tbl[7]  = v(0, 2'b11, 2'b00, 10'h010, 0, 0, 10'h020, 0, 0, 2'b01, 0, 1, 2'b01, 32'hA500_0010);
    tbl[8]  = v(0, 2'b11, 2'b00, 10'h010, 0, 0, 10'h020, 0, 0, 2'b10, 0, 1, 2'b10, 32'hA500_0020);
    tbl[9]  = v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b01, 32'hA500_0010);
    tbl[10] = v(0, 2'b01, 2'b01, 10'h005, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b01, 1, 1, 2'b10, 32'hA500_0020);
    tbl[11] = v(0, 2'b01, 2'b00, 10'h005, 0, 0, 0, 0, 0, 2'b01, 0, 0, 2'b01, 32'hA500_0010);
    tbl[12] = v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b10, 32'hA500_0020);
    tbl[13] = v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2'b00, 0);
    tbl[14] = tbl[13];
    tbl[15] = v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2'b01, 32'hDEAD_BEEF);
    tbl[16] = v(0, 2'b10, 2'b10, 0, 0, 0, 10'h3FF, 32'h1122_3344, 4'hF, 2'b10, 1, 1, 2'b00, 0);
    tbl[17] = v(0, 2'b10, 2'b10, 0, 0, 0, 10'h3FF, 32'hAABB_CCDD, 4'h2, 2'b10, 0, 0, 2'b00, 0);
    tbl[18] = v(0, 2'b10, 2'b00, 0, 0, 0, 10'h3FF, 0, 0, 2'b10, 0, 0, 2'b00, 0);
    tbl[19] = v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0);
    tbl[20] = tbl[13];
    tbl[21] = tbl[13];
    tbl[22] = v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2'b10, 32'h1122_CC44);
    tbl[23] = v(0, 2'b10, 2'b00, 0, 0, 0, 10'h030, 0, 0, 2'b10, 1, 1, 2'b00, 0);
    tbl[24] = tbl[19];
    tbl[25] = tbl[13];
    tbl[26] = v(0, 2'b10, 2'b00, 0, 0, 0, 10'h031, 0, 0, 2'b10, 1, 1, 2'b00, 0);
    tbl[27] = v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b10, 32'hA500_0030);
    tbl[28] = tbl[13];
    tbl[29] = v(0, 2'b10, 2'b00, 0, 0, 0, 10'h032, 0, 0, 2'b10, 1, 1, 2'b00, 0);
    tbl[30] = v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b10, 32'hA500_0031);
    tbl[31] = tbl[13];
    tbl[32] = v(0, 2'b11, 2'b00, 10'h040, 0, 0, 10'h041, 0, 0, 2'b01, 1, 1, 2'b00, 0);
    tbl[33] = v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 2'b10, 32'hA500_0032);
    tbl[34] = tbl[13];
    tbl[35] = tbl[13];
    tbl[36] = v(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2'b01, 32'hA500_0040);

    drive(1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
    @(posedge clk0);

    for (int i = 0; i < 37; i++) begin
      @(negedge clk0);
      drive(tbl[i].rst, tbl[i].vld, tbl[i].we, tbl[i].a0, tbl[i].d0, tbl[i].m0,
            tbl[i].a1, tbl[i].d1, tbl[i].m1);
      #1;
      chk($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d mem_csb0", i), 32'(mem_csb0), 32'(tbl[i].e_csb));
      chk($sformatf("row%0d mem_web0", i), 32'(mem_web0), 32'(tbl[i].e_web));
      chk($sformatf("row%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv != 2'b00)
        chk($sformatf("row%0d rsp_data", i), bus.rsp_data, tbl[i].e_rd);
    end

    // Reset during an in-flight read. The pointer sits at 1 here, so a
    // grant to requester 0 with both valid afterwards shows it was reset.
    @(negedge clk0);
    drive(0, 2'b01, 2'b00, 10'h050, 0, 0, 0, 0, 0);
    #1 chk("rstmid issue ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk0);
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk0);
    drive(1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
    #1 chk("rstmid ready in reset", 32'(bus.req_ready), 32'h0);
    @(negedge clk0);
    drive(0, 2'b11, 2'b00, 10'h060, 0, 0, 10'h061, 0, 0);
    #1;
    chk("rstmid ptr reset grant", 32'(bus.req_ready), 32'h1);
    chk("rstmid csb0", 32'(mem_csb0), 32'h1);
    chk("rstmid web0", 32'(mem_web0), 32'h1);
    chk("rstmid wmask0", 32'(mem_wmask0), 32'h0);
    chk("rstmid address", 32'(mem_address), 32'h0);
    chk("rstmid datain", mem_datain, 32'h0);
    chk("rstmid rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rstmid rsp_data", bus.rsp_data, 32'h0);
    @(negedge clk0);
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post-rst address", 32'(mem_address), 32'h060);
    chk("post-rst wmask0", 32'(mem_wmask0), 32'hF);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dropped read slot%0d rsp_valid", k), 32'(bus.rsp_valid), 32'h0);
      @(negedge clk0);
      #1;
    end
    chk("post-rst read rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("post-rst read rsp_data", bus.rsp_data, 32'hA500_0060);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
